// File: rtl/sync_down_counter6.sv
// Synchronous presettable down counter built from JK toggle flip-flops with a parallel borrow chain.
// Optional macro JK_DOWN_RELOAD_EN: underflow reloads the last loaded preset instead of wrapping to all ones.
module sync_down_counter6 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             zero,
  output logic             borrow
);

  logic [WIDTH-1:0] r_q;
  logic             r_borrow;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_jk_next;
  logic [WIDTH-1:0] w_count_next;
  logic             w_q_zero;
  logic             w_underflow;

  // Bit i toggles only when every lower bit is already zero, decoded in parallel.
  assign w_t[0] = en;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow_chain
      assign w_t[gi] = en & (r_q[gi-1:0] == '0);
    end
  endgenerate

  // JK flip-flop next-state with J = K = T: Q+ = J&~Q | ~K&Q.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
      assign w_jk_next[gi] = (w_t[gi] & ~r_q[gi]) | (~w_t[gi] & r_q[gi]);
    end
  endgenerate

  assign w_q_zero    = (r_q == '0);
  assign w_underflow = en & w_q_zero;

`ifdef JK_DOWN_RELOAD_EN
  logic [WIDTH-1:0] r_reload;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_reload <= '1;
    end else if (load) begin
      r_reload <= din;
    end
  end

  assign w_count_next = w_underflow ? r_reload : w_jk_next;
`else
  // Toggling every bit from zero already yields all ones, so no override is needed.
  assign w_count_next = w_jk_next;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      r_q      <= '0;
      r_borrow <= 1'b0;
    end else if (load) begin
      r_q      <= din;
      r_borrow <= 1'b0;
    end else begin
      r_q      <= w_count_next;
      r_borrow <= w_underflow;
    end
  end

  assign q      = r_q;
  assign qn     = ~r_q;
  assign zero   = w_q_zero;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_sync_down_counter6.sv
// Randomised and directed bench for sync_down_counter6 against an integer reference model.
// Honours JK_DOWN_RELOAD_EN the same way as the design.
module tb_sync_down_counter6;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [5:0] din = 6'd0;
  logic [5:0] q;
  logic [5:0] qn;
  logic       zero;
  logic       borrow;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_q   = 0;
  int m_rel = 63;
  int m_b   = 0;

  sync_down_counter6 #(.WIDTH(6)) dut (
    .clk    (clk),
    .clear  (clear),
    .en     (en),
    .load   (load),
    .din    (din),
    .q      (q),
    .qn     (qn),
    .zero   (zero),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  task automatic step(input logic c, input logic l, input logic e, input int d);
    clear = c;
    load  = l;
    en    = e;
    din   = 6'(d);
    @(posedge clk);
    #1;
    if (c) begin
      m_q = 0; m_rel = 63; m_b = 0;
    end else if (l) begin
      m_q = d % 64; m_rel = d % 64; m_b = 0;
    end else if (e) begin
      if (m_q == 0) begin
`ifdef JK_DOWN_RELOAD_EN
        m_q = m_rel;
`else
        m_q = 63;
`endif
        m_b = 1;
      end else begin
        m_q = m_q - 1;
        m_b = 0;
      end
    end else begin
      m_b = 0;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, int'($urandom_range(1, 63)));
    step(1'b1, 1'b1, 1'b1, int'($urandom_range(1, 63)));
    total++;
    if (q !== 6'd0 || qn !== 6'b111111 || zero !== 1'b1 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL reset: q=%0d qn=%b zero=%b borrow=%b required q=0 qn=111111 zero=1 borrow=0", q, qn, zero, borrow);
    end
    $display("reset: q=%0d qn=%b zero=%b borrow=%b", q, qn, zero, borrow);
  endtask

  task automatic test_free_count();
    int exp_q;
    int exp_b;
    step(1'b1, 1'b0, 1'b0, 0);
    for (int n = 1; n <= 65; n++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      exp_q = (64 - n) % 64;
      exp_b = (n == 1 || n == 65) ? 1 : 0;
      total++;
      if (q !== 6'(exp_q) || qn !== ~6'(exp_q) || zero !== (exp_q == 0) || borrow !== 1'(exp_b)) begin
        bad++;
        $display("FAIL free_count[%0d]: q=%0d qn=%b zero=%b borrow=%b required q=%0d zero=%0d borrow=%0d",
                 n, q, qn, zero, borrow, exp_q, exp_q == 0, exp_b);
      end
      $display("free_count[%0d]: q=%0d borrow=%b", n, q, borrow);
    end
  endtask

  task automatic test_load_priority();
    step(1'b0, 1'b1, 1'b1, 5);
    total++;
    if (q !== 6'd5 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL load_priority: q=%0d borrow=%b required q=5 borrow=0", q, borrow);
    end
    $display("load_priority: q=%0d", q);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      total++;
      if (q !== 6'(5 - k) || zero !== (k == 5) || borrow !== 1'b0) begin
        bad++;
        $display("FAIL load_count[%0d]: q=%0d zero=%b borrow=%b required q=%0d zero=%0d borrow=0",
                 k, q, zero, borrow, 5 - k, k == 5);
      end
      $display("load_count[%0d]: q=%0d zero=%b", k, q, zero);
    end
  endtask

  task automatic test_reload();
    int exp_q[5];
    int exp_b[5];
`ifdef JK_DOWN_RELOAD_EN
    exp_q = '{2, 1, 0, 3, 2};
`else
    exp_q = '{2, 1, 0, 63, 62};
`endif
    exp_b = '{0, 0, 0, 1, 0};
    step(1'b0, 1'b1, 1'b0, 3);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b1, 0);
      total++;
      if (q !== 6'(exp_q[k]) || borrow !== 1'(exp_b[k])) begin
        bad++;
        $display("FAIL reload[%0d]: q=%0d borrow=%b required q=%0d borrow=%0d", k, q, borrow, exp_q[k], exp_b[k]);
      end
      $display("reload[%0d]: q=%0d borrow=%b", k, q, borrow);
    end
  endtask

  task automatic test_mid_clear();
    step(1'b0, 1'b1, 1'b0, 40);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 0);
    total++;
    if (q !== 6'd37) begin
      bad++;
      $display("FAIL mid_count: q=%0d required 37", q);
    end
    step(1'b1, 1'b0, 1'b1, 0);
    total++;
    if (q !== 6'd0 || borrow !== 1'b0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL mid_clear: q=%0d borrow=%b zero=%b required q=0 borrow=0 zero=1", q, borrow, zero);
    end
    step(1'b0, 1'b0, 1'b1, 0);
    total++;
    if (q !== 6'd63 || borrow !== 1'b1) begin
      bad++;
      $display("FAIL post_clear_underflow: q=%0d borrow=%b required q=63 borrow=1", q, borrow);
    end
    $display("mid_clear: q=%0d borrow=%b", q, borrow);
  endtask

  task automatic test_hold();
    step(1'b0, 1'b1, 1'b0, 10);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, int'($urandom_range(0, 63)));
      total++;
      if (q !== 6'd10 || qn !== 6'b110101 || borrow !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: q=%0d qn=%b borrow=%b required q=10 qn=110101 borrow=0", k, q, qn, borrow);
      end
      $display("hold[%0d]: q=%0d qn=%b", k, q, qn);
    end
  endtask

  task automatic test_zero_edges();
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);
    total++;
    if (q !== 6'd0 || zero !== 1'b1 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL zero_hold: q=%0d zero=%b borrow=%b required q=0 zero=1 borrow=0", q, zero, borrow);
    end
    step(1'b0, 1'b1, 1'b1, 7);
    total++;
    if (q !== 6'd7 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL load_at_zero: q=%0d borrow=%b required q=7 borrow=0", q, borrow);
    end
    $display("zero_edges: q=%0d borrow=%b", q, borrow);
  endtask

  task automatic test_random();
    logic c;
    logic l;
    logic e;
    int   d;
    for (int k = 0; k < 400; k++) begin
      c = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 63));
      step(c, l, e, d);
      total++;
      if (q !== 6'(m_q) || qn !== ~6'(m_q) || zero !== (m_q == 0) || borrow !== 1'(m_b)) begin
        bad++;
        $display("FAIL random[%0d]: q=%0d qn=%b zero=%b borrow=%b required q=%0d borrow=%0d",
                 k, q, qn, zero, borrow, m_q, m_b);
      end
      $display("random[%0d]: clr=%b ld=%b en=%b din=%0d q=%0d borrow=%b", k, c, l, e, d, q, borrow);
    end
  endtask

  initial begin
    test_reset();
    test_free_count();
    test_load_priority();
    test_reload();
    test_mid_clear();
    test_hold();
    test_zero_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
